reg4_seq: RTL and testbench
===========================

# reg4_seq

Sequencer and two-requester arbiter for a single `register4` 4-bit shift register. It grants one requester at a time and runs a fixed job on the register: parallel-load a 4-bit word, then shift it SHIFT_CNT times while feeding serial-in bits. During the shifts it captures the serial-out stream. When the job finishes it returns the captured bits and the final register contents on a response handshake. It sits between the requesting logic and the `register4` ports: it drives ENB, DIR, S_IN, MODO and D, and observes Q and S_OUT.

## Interface
- SHIFT_CNT, 4, number of shift cycles per job; legal values 1..4.

- CLK  in  1  clock; all state changes on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- REQ_VALID  in  2  per-requester request valid; bit i belongs to requester i.
- REQ_READY  out  2  per-requester accept strobe; one-hot, single cycle.
- REQ_DIR  in  2  shift direction per requester.
- REQ_D  in  8  parallel load word; [3:0] is requester 0, [7:4] is requester 1.
- REQ_SIN  in  8  serial-in bits per requester; bit k is used in shift cycle k.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response accept.
- RSP_ID  out  1  index of the requester that owns the response.
- RSP_SO  out  4  captured S_OUT bits; bit k is from shift cycle k; bits ≥ SHIFT_CNT are 0.
- RSP_Q  out  4  register Q sampled at job completion.
- REG_ENB, REG_DIR, REG_S_IN  out  1 each  drive `register4` ENB, DIR and S_IN.
- REG_MODO  out  2  drives `register4` MODO.
- REG_D  out  4  drives `register4` D.
- REG_Q  in  4  from `register4` Q.
- REG_S_OUT  in  1  from `register4` S_OUT.

## Operation
- MODO encoding driven: 2'b10 parallel load, 2'b00 shift, 2'b11 hold. Rotate (2'b01) is never issued.
- DIR convention:
  - DIR=0 shifts right: Q[3]←S_IN, S_OUT=Q[0].
  - DIR=1 shifts left: Q[0]←S_IN, S_OUT=Q[3].
- FSM states:
  - IDLE: ENB=0, MODO=11. If any REQ_VALID bit is set, pick a winner, pulse REQ_READY[winner], latch DIR/D/SIN/ID, and go to LOAD.
  - LOAD (1 cycle): ENB=1, MODO=10, D=latched word. Go to SHIFT with cnt=0.
  - SHIFT (SHIFT_CNT cycles): ENB=1, MODO=00, DIR=latched, S_IN=sin[cnt]. Capture so[cnt]←REG_S_OUT at the edge and increment cnt. When cnt=SHIFT_CNT−1, go to DONE and register RSP_Q←post-shift Q.
  - DONE: ENB=0, MODO=11, RSP_VALID=1. On RSP_READY, go to IDLE.
- REG_S_OUT is sampled as the value present during the shift cycle, i.e. the bit being shifted out at that edge.
- Arbitration is round-robin:
  - A pointer marks the preferred requester; reset value is 0.
  - After granting requester i, the pointer moves to 1−i.
  - A single active request is granted regardless of the pointer.
- Requester rules: REQ_VALID and its fields must stay stable until REQ_READY. The request is consumed on the REQ_READY cycle.
- No new grant is issued while the FSM is in LOAD, SHIFT or DONE. REQ_READY stays 0 in those states.
- RSP_ID, RSP_SO and RSP_Q stay stable while RSP_VALID=1.

## Timing
- Reset, applied on any edge where RST_N=0:
  - state=IDLE, pointer=0, cnt=0.
  - REQ_READY=0, RSP_VALID=0, RSP_ID=0, RSP_SO=0, RSP_Q=0.
  - REG_ENB=0, REG_DIR=0, REG_S_IN=0, REG_MODO=2'b11, REG_D=0.
- Reset mid-job: the next cycle is IDLE and the granted request is dropped. RSP_VALID=0 and the register is left at its current contents, with no further ENB.
- Register-side outputs are a Moore decode of state, cnt and latched fields. They have no combinational path from REQ_* or RSP_READY.
- REQ_READY is a Mealy output in IDLE only, derived from REQ_VALID and the pointer.
- Latency: accept in cycle t, LOAD in t+1, SHIFT in t+2..t+1+SHIFT_CNT, RSP_VALID first high in t+2+SHIFT_CNT. With the default this is cycle t+6.
- Back-to-back: with RSP_READY=1 in the first DONE cycle, IDLE follows, so the next accept is no earlier than t+3+SHIFT_CNT.
- A REQ_VALID that arrives while busy waits and is granted in the first IDLE cycle.

## Configuration
- REG4_SEQ_FIXED_PRIO_EN
  - Defined: requester 0 always wins when both are valid, and the pointer logic is removed.
  - Undefined (default): round-robin as specified under Operation.

## Test plan
- Requester 0 with D=4'b1011, DIR=0, SIN=4'b0000, SHIFT_CNT=4 → RSP_ID=0, RSP_SO=4'b1011, RSP_Q=4'b0000, RSP_VALID exactly 6 cycles after REQ_READY[0].
- Requester 1 with D=4'b1000, DIR=1, SIN=4'b1111 → RSP_SO=4'b0001, RSP_Q=4'b1111; REG_MODO sequence is 11,10,00,00,00,00,11.
- Both requesters valid and held after reset: grants alternate 0,1,0,1 over four jobs. With REG4_SEQ_FIXED_PRIO_EN defined, the grants are 0,0,0,0.
- RSP_READY held low for 5 cycles in DONE: RSP_* stay stable, REG_ENB=0, and the waiting requester sees no REQ_READY until the cycle after RSP_READY.
- RST_N=0 for one cycle during the second SHIFT cycle: the next cycle is IDLE with all outputs at reset values, and no RSP_VALID is produced for the aborted job.
- SHIFT_CNT=2, D=4'b0110, DIR=0, SIN=4'b0011 → RSP_SO=4'b0010, RSP_Q=4'b1101.

Source files
------------

// File: rtl/reg4_seq.sv
// reg4_seq: two-requester arbiter and job sequencer (load, then SHIFT_CNT shifts) for one register4.
// Build option REG4_SEQ_FIXED_PRIO_EN: requester 0 always wins ties and the round-robin pointer is removed.
module reg4_seq #(
  parameter int SHIFT_CNT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req_valid,
  output logic [1:0] o_req_ready,
  input  logic [1:0] i_req_dir,
  input  logic [7:0] i_req_d,
  input  logic [7:0] i_req_sin,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic       o_rsp_id,
  output logic [3:0] o_rsp_so,
  output logic [3:0] o_rsp_q,
  output logic       o_reg_enb,
  output logic       o_reg_dir,
  output logic       o_reg_s_in,
  output logic [1:0] o_reg_modo,
  output logic [3:0] o_reg_d,
  input  logic [3:0] i_reg_q,
  input  logic       i_reg_s_out,
  output logic [1:0] o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a requester holds valid and its fields until then, and RSP_* hold while o_rsp_valid=1.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  logic [1:0] r_cnt;
  logic       r_dir;
  logic [3:0] r_sin;
  logic       r_rsp_valid;
  logic       r_rsp_id;
  logic [3:0] r_rsp_so;
  logic [3:0] r_rsp_q;
  logic       r_reg_enb;
  logic       r_reg_dir;
  logic       r_reg_s_in;
  logic [1:0] r_reg_modo;
  logic [3:0] r_reg_d;

  logic       w_win;
  logic       w_accept;
  logic       w_last;
  logic [1:0] w_next_cnt;
  logic [3:0] w_post_q;

  assign w_accept = (r_state == S_IDLE) && i_rst_n && (|i_req_valid);

`ifdef REG4_SEQ_FIXED_PRIO_EN
  assign w_win = ~i_req_valid[0];
`else
  logic r_ptr;
  assign w_win = (&i_req_valid) ? r_ptr : i_req_valid[1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_accept) begin
      r_ptr <= ~w_win;
    end
  end
`endif

  assign o_req_ready = w_accept ? (w_win ? 2'b10 : 2'b01) : 2'b00;

  assign w_last     = (r_cnt == 2'(SHIFT_CNT - 1));
  assign w_next_cnt = r_cnt + 2'd1;
  // Q as it will be after this edge's shift, so RSP_Q is valid in the first DONE cycle.
  assign w_post_q   = r_reg_dir ? {i_reg_q[2:0], r_reg_s_in} : {r_reg_s_in, i_reg_q[3:1]};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_dir       <= 1'b0;
      r_sin       <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_so    <= 4'd0;
      r_rsp_q     <= 4'd0;
      r_reg_enb   <= 1'b0;
      r_reg_dir   <= 1'b0;
      r_reg_s_in  <= 1'b0;
      r_reg_modo  <= 2'b11;
      r_reg_d     <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_LOAD;
            r_dir      <= i_req_dir[w_win];
            r_sin      <= w_win ? i_req_sin[7:4] : i_req_sin[3:0];
            r_rsp_id   <= w_win;
            r_rsp_so   <= 4'd0;
            r_cnt      <= 2'd0;
            r_reg_enb  <= 1'b1;
            r_reg_modo <= 2'b10;
            r_reg_d    <= w_win ? i_req_d[7:4] : i_req_d[3:0];
          end
        end
        S_LOAD: begin
          r_state    <= S_SHIFT;
          r_cnt      <= 2'd0;
          r_reg_modo <= 2'b00;
          r_reg_dir  <= r_dir;
          r_reg_s_in <= r_sin[0];
        end
        S_SHIFT: begin
          r_rsp_so[r_cnt] <= i_reg_s_out;
          r_cnt           <= w_next_cnt;
          r_reg_s_in      <= r_sin[w_next_cnt];
          if (w_last) begin
            r_state     <= S_DONE;
            r_cnt       <= 2'd0;
            r_reg_enb   <= 1'b0;
            r_reg_modo  <= 2'b11;
            r_rsp_q     <= w_post_q;
            r_rsp_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (i_rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_so    = r_rsp_so;
  assign o_rsp_q     = r_rsp_q;
  assign o_reg_enb   = r_reg_enb;
  assign o_reg_dir   = r_reg_dir;
  assign o_reg_s_in  = r_reg_s_in;
  assign o_reg_modo  = r_reg_modo;
  assign o_reg_d     = r_reg_d;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_reg4_seq.sv
// Bench for reg4_seq: register4 models, queue scoreboard, directed scenarios and random traffic.
module tb_reg4_seq;
  localparam int SC = 4;
`ifdef REG4_SEQ_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0] req_valid, req_ready, req_dir;
  logic [7:0] req_d, req_sin;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [3:0] rsp_so, rsp_q;
  logic       reg_enb, reg_dir, reg_s_in, reg_s_out;
  logic [1:0] reg_modo, dbg_state;
  logic [3:0] reg_d;
  logic [3:0] reg_q = 4'd0;

  reg4_seq #(.SHIFT_CNT(SC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_dir(req_dir), .i_req_d(req_d), .i_req_sin(req_sin), .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id), .o_rsp_so(rsp_so), .o_rsp_q(rsp_q),
    .o_reg_enb(reg_enb), .o_reg_dir(reg_dir), .o_reg_s_in(reg_s_in), .o_reg_modo(reg_modo),
    .o_reg_d(reg_d), .i_reg_q(reg_q), .i_reg_s_out(reg_s_out), .o_dbg_state(dbg_state)
  );

  // second instance with two shifts per job
  logic [1:0] b_req_valid, b_req_ready, b_req_dir;
  logic [7:0] b_req_d, b_req_sin;
  logic       b_rsp_valid, b_rsp_ready, b_rsp_id;
  logic [3:0] b_rsp_so, b_rsp_q;
  logic       b_reg_enb, b_reg_dir, b_reg_s_in, b_reg_s_out;
  logic [1:0] b_reg_modo, b_dbg_state;
  logic [3:0] b_reg_d;
  logic [3:0] b_reg_q = 4'd0;

  reg4_seq #(.SHIFT_CNT(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
    .i_req_dir(b_req_dir), .i_req_d(b_req_d), .i_req_sin(b_req_sin), .o_rsp_valid(b_rsp_valid),
    .i_rsp_ready(b_rsp_ready), .o_rsp_id(b_rsp_id), .o_rsp_so(b_rsp_so), .o_rsp_q(b_rsp_q),
    .o_reg_enb(b_reg_enb), .o_reg_dir(b_reg_dir), .o_reg_s_in(b_reg_s_in), .o_reg_modo(b_reg_modo),
    .o_reg_d(b_reg_d), .i_reg_q(b_reg_q), .i_reg_s_out(b_reg_s_out), .o_dbg_state(b_dbg_state)
  );

  // ---------------- register4 models ----------------
  always @(posedge clk) begin
    if (reg_enb) begin
      case (reg_modo)
        2'b10: reg_q <= reg_d;
        2'b00: reg_q <= reg_dir ? {reg_q[2:0], reg_s_in} : {reg_s_in, reg_q[3:1]};
        2'b01: reg_q <= reg_dir ? {reg_q[2:0], reg_q[3]} : {reg_q[0], reg_q[3:1]};
        default: ;
      endcase
    end
  end
  assign reg_s_out = reg_dir ? reg_q[3] : reg_q[0];

  always @(posedge clk) begin
    if (b_reg_enb) begin
      case (b_reg_modo)
        2'b10: b_reg_q <= b_reg_d;
        2'b00: b_reg_q <= b_reg_dir ? {b_reg_q[2:0], b_reg_s_in} : {b_reg_s_in, b_reg_q[3:1]};
        2'b01: b_reg_q <= b_reg_dir ? {b_reg_q[2:0], b_reg_q[3]} : {b_reg_q[0], b_reg_q[3:1]};
        default: ;
      endcase
    end
  end
  assign b_reg_s_out = b_reg_dir ? b_reg_q[3] : b_reg_q[0];

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];
  logic       grants[$];
  int         checks = 0;
  int         errors = 0;
  bit         busy = 1'b0;
  bit         exp_ptr = 1'b0;
  int         since = 0;
  logic [3:0] cur_d, cur_sin;
  logic       cur_dir;
  logic [8:0] last_rsp = 9'd0;
  bit         taken[2];
  bit         refill[2];
  bit         rand_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: job result from the word, direction and serial-in bits, using plain arithmetic.
  function automatic logic [8:0] model(input logic id, input logic dir, input logic [3:0] d,
                                       input logic [3:0] sin, input int n);
    int q;
    logic [3:0] so;
    q  = int'(d);
    so = 4'd0;
    for (int k = 0; k < n; k++) begin
      if (dir) begin
        so[k] = 1'(q / 8);
        q     = (q * 2 + int'(sin[k])) % 16;
      end else begin
        so[k] = 1'(q % 2);
        q     = q / 2 + 8 * int'(sin[k]);
      end
    end
    return {id, so, 4'(q)};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [1:0] want;
    logic       w;
    logic [8:0] got;
    if (!rst_n) begin
      check("ready_in_reset", 32'(req_ready), 0);
      exp_q.delete();
      busy = 1'b0;
      exp_ptr = 1'b0;
      since = 0;
    end else begin
      want = 2'b00;
      w = 1'b0;
      if (!busy && req_valid != 2'b00) begin
        w = (req_valid == 2'b11) ? (FIXED ? 1'b0 : exp_ptr) : req_valid[1];
        want = w ? 2'b10 : 2'b01;
      end
      check("req_ready", 32'(req_ready), 32'(want));
      if (busy) begin
        if (since == 1) begin
          check("load_enb", 32'(reg_enb), 1);
          check("load_modo", 32'(reg_modo), 2);
          check("load_d", 32'(reg_d), 32'(cur_d));
        end else if (since <= SC + 1) begin
          check("shift_enb", 32'(reg_enb), 1);
          check("shift_modo", 32'(reg_modo), 0);
          check("shift_dir", 32'(reg_dir), 32'(cur_dir));
          check("shift_sin", 32'(reg_s_in), 32'(cur_sin[since-2]));
        end else begin
          check("done_enb", 32'(reg_enb), 0);
          check("done_modo", 32'(reg_modo), 3);
        end
        if (since == SC + 1) check("rsp_early", 32'(rsp_valid), 0);
        if (since == SC + 2) check("rsp_latency", 32'(rsp_valid), 1);
        since++;
      end else begin
        check("idle_enb", 32'(reg_enb), 0);
      end
      if (want != 2'b00) begin
        cur_dir = req_dir[w];
        cur_d   = w ? req_d[7:4] : req_d[3:0];
        cur_sin = w ? req_sin[7:4] : req_sin[3:0];
        exp_q.push_back(model(w, cur_dir, cur_d, cur_sin, SC));
        grants.push_back(w);
        exp_ptr = ~w;
        busy = 1'b1;
        since = 1;
        taken[w] = 1'b1;
      end
      if (rsp_valid) begin
        got = {rsp_id, rsp_so, rsp_q};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got %0h, expected no response (t=%0t)", got, $time);
        end else begin
          check("rsp", 32'(got), 32'(exp_q[0]));
          if (rsp_ready) begin
            last_rsp = got;
            void'(exp_q.pop_front());
            busy = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic dir, input logic [3:0] d, input logic [3:0] sin);
    req_valid[i]      = 1'b1;
    req_dir[i]        = dir;
    req_d[i*4 +: 4]   = d;
    req_sin[i*4 +: 4] = sin;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (taken[i]) begin
        taken[i] = 1'b0;
        if (refill[i]) set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        else req_valid[i] = 1'b0;
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < 2; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic run_quiet(input string name);
    int n;
    n = 0;
    while ((req_valid != 2'b00 || busy) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles, expected idle", name, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 0);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_rsp"}, 32'({rsp_valid, rsp_id, rsp_so, rsp_q}), 0);
    check({tag, "_reg"}, 32'({reg_enb, reg_dir, reg_s_in, reg_d}), 0);
    check({tag, "_modo"}, 32'(reg_modo), 3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [8:0] snap;
    logic [3:0] q_hold;
    int n;
    rst_n = 1'b0;
    req_valid = 2'b00; req_dir = 2'b00; req_d = 8'd0; req_sin = 8'd0; rsp_ready = 1'b1;
    b_req_valid = 2'b00; b_req_dir = 2'b00; b_req_d = 8'd0; b_req_sin = 8'd0; b_rsp_ready = 1'b1;
    refill[0] = 1'b0; refill[1] = 1'b0; taken[0] = 1'b0; taken[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // requester 0, right shift of 1011 with zero fill
    set_req(0, 1'b0, 4'b1011, 4'b0000);
    run_quiet("job0");
    check("job0_result", 32'(last_rsp), 32'({1'b0, 4'b1011, 4'b0000}));

    // requester 1, left shift of 1000 with ones fill
    set_req(1, 1'b1, 4'b1000, 4'b1111);
    run_quiet("job1");
    check("job1_result", 32'(last_rsp), 32'({1'b1, 4'b0001, 4'b1111}));

    // both requesters held from reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    grants.delete();
    refill[0] = 1'b1; refill[1] = 1'b1;
    set_req(0, 1'b0, 4'h5, 4'h3);
    set_req(1, 1'b1, 4'hA, 4'hC);
    n = 0;
    while (grants.size() < 4 && n < 200) begin step(); n++; end
    refill[0] = 1'b0; refill[1] = 1'b0;
    if (grants.size() >= 4) begin
      check("grant_0", 32'(grants[0]), 0);
      check("grant_1", 32'(grants[1]), FIXED ? 0 : 1);
      check("grant_2", 32'(grants[2]), 0);
      check("grant_3", 32'(grants[3]), FIXED ? 0 : 1);
    end else begin
      checks++; errors++;
      $display("FAIL grant_seq: got %0d grants, expected 4", grants.size());
    end
    run_quiet("arb");

    // response stall with a waiting requester
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 4'h9, 4'h6);
    step();
    set_req(1, 1'b0, 4'h3, 4'hF);
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    check("stall_rsp_seen", 32'(rsp_valid), 1);
    snap = {rsp_id, rsp_so, rsp_q};
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", 32'(rsp_valid), 1);
      check("stall_fields", 32'({rsp_id, rsp_so, rsp_q}), 32'(snap));
      check("stall_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    step();
    check("grant_after_release", 32'(req_ready), 32'(2'b10));
    run_quiet("stall");

    // reset pulse during the second shift cycle
    set_req(0, 1'b0, 4'hE, 4'h1);
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_reset_outputs("midreset");
    q_hold = reg_q;
    repeat (12) step();
    check("midreset_q_held", 32'(reg_q), 32'(q_hold));
    check("midreset_no_rsp", 32'(rsp_valid), 0);

    // random traffic
    rand_mode = 1'b1;
    repeat (400) step();
    rand_mode = 1'b0;
    rsp_ready = 1'b1;
    run_quiet("random");

    // two-shift instance
    b_req_valid = 2'b01; b_req_dir = 2'b00; b_req_d = 8'h06; b_req_sin = 8'h03;
    n = 0;
    while (b_req_ready !== 2'b01 && n < 20) begin @(posedge clk); #1; n++; end
    check("b_grant", 32'(b_req_ready), 32'(2'b01));
    @(posedge clk);
    #1;
    b_req_valid = 2'b00;
    n = 1;
    while (!b_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("b_latency", 32'(n), 4);
    check("b_result", 32'({b_rsp_id, b_rsp_so, b_rsp_q}), 32'({1'b0, 4'b0010, 4'b1101}));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
